// File: rtl/cw_seq_pkg.sv
// Shared types and encodings for the control-word sequencer: states, instruction
// classes, ALU op codes, supported opcode/func values and control-word bit positions.
package cw_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    RTYPE = 3'd0,
    ITYPE = 3'd1,
    LOAD  = 3'd2,
    STORE = 3'd3,
    NOP   = 3'd4
  } iclass_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_NOP   = 6'h15;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [10:0] FN_ADD = 11'h020;
  localparam logic [10:0] FN_SUB = 11'h022;
  localparam logic [10:0] FN_AND = 11'h024;
  localparam logic [10:0] FN_OR  = 11'h025;

  localparam int unsigned CW_W    = 32'd13;
  localparam int unsigned CW_RF1  = 32'd12;
  localparam int unsigned CW_RF2  = 32'd11;
  localparam int unsigned CW_EN1  = 32'd10;
  localparam int unsigned CW_S1   = 32'd9;
  localparam int unsigned CW_S2   = 32'd8;
  localparam int unsigned CW_ALU1 = 32'd7;
  localparam int unsigned CW_ALU2 = 32'd6;
  localparam int unsigned CW_EN2  = 32'd5;
  localparam int unsigned CW_RM   = 32'd4;
  localparam int unsigned CW_WM   = 32'd3;
  localparam int unsigned CW_EN3  = 32'd2;
  localparam int unsigned CW_S3   = 32'd1;
  localparam int unsigned CW_WF1  = 32'd0;

endpackage

// File: rtl/cw_seq_ctrl_if.sv
// Instruction issue handshake between an instruction source (master) and the
// control-word sequencer (slave).
interface cw_seq_ctrl_if #(
  parameter int OP_CODE_SIZE = 6,
  parameter int FUNC_SIZE    = 11
);
  logic                    instr_valid;
  logic                    instr_ready;
  logic [OP_CODE_SIZE-1:0] opcode;
  logic [FUNC_SIZE-1:0]    func;

  modport master (output instr_valid, output opcode, output func, input instr_ready);
  modport slave  (input instr_valid, input opcode, input func, output instr_ready);
endinterface

// File: rtl/cw_decode.sv
// Combinational instruction classifier: opcode/func to instruction class,
// ALU operation and legality.
module cw_decode
  import cw_seq_pkg::*;
#(
  parameter int OP_CODE_SIZE = 6,
  parameter int FUNC_SIZE    = 11
) (
  input  logic [OP_CODE_SIZE-1:0] opcode,
  input  logic [FUNC_SIZE-1:0]    func,
  output iclass_t                 iclass,
  output alu_op_t                 alu_op,
  output logic                    legal
);

  // Classify the encoding; anything unlisted falls through as illegal.
  always_comb begin
    iclass = NOP;
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (opcode)
      OP_CODE_SIZE'(OP_RTYPE): begin
        iclass = RTYPE;
        case (func)
          FUNC_SIZE'(FN_ADD): alu_op = ALU_ADD;
          FUNC_SIZE'(FN_SUB): alu_op = ALU_SUB;
          FUNC_SIZE'(FN_AND): alu_op = ALU_AND;
          FUNC_SIZE'(FN_OR):  alu_op = ALU_OR;
          default:            legal  = 1'b0;
        endcase
      end
      OP_CODE_SIZE'(OP_ADDI): begin iclass = ITYPE; alu_op = ALU_ADD; end
      OP_CODE_SIZE'(OP_SUBI): begin iclass = ITYPE; alu_op = ALU_SUB; end
      OP_CODE_SIZE'(OP_ANDI): begin iclass = ITYPE; alu_op = ALU_AND; end
      OP_CODE_SIZE'(OP_ORI):  begin iclass = ITYPE; alu_op = ALU_OR;  end
      OP_CODE_SIZE'(OP_LW):   iclass = LOAD;
      OP_CODE_SIZE'(OP_SW):   iclass = STORE;
      OP_CODE_SIZE'(OP_NOP):  iclass = NOP;
      default:                legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/cw_seq_ctrl.sv
// Handshaked multi-cycle control-word sequencer: walks each accepted instruction
// through DECODE/EXECUTE/MEMORY/WRITEBACK with memory wait, timeout and flush.
module cw_seq_ctrl
  import cw_seq_pkg::*;
#(
  parameter int OP_CODE_SIZE = 6,
  parameter int FUNC_SIZE    = 11,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst,
  cw_seq_ctrl_if.slave    ib,
  input  logic            mem_ready,
  input  logic            flush,
  output logic [CW_W-1:0] cw,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            mem_err
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state_r;
  iclass_t         cls_r;
  alu_op_t         alu_r;
  logic [TO_W-1:0] cnt_r;
  logic            illegal_r;
  logic            mem_err_r;

  iclass_t         cls_s;
  alu_op_t         alu_s;
  logic            legal_s;
  logic            ready_s;
  logic            hs_s;
  logic [CW_W-1:0] cw_s;

  cw_decode #(
    .OP_CODE_SIZE(OP_CODE_SIZE),
    .FUNC_SIZE   (FUNC_SIZE)
  ) u_decode (
    .opcode(ib.opcode),
    .func  (ib.func),
    .iclass(cls_s),
    .alu_op(alu_s),
    .legal (legal_s)
  );

  // Ready is held low during reset so no instruction is offered to a sequencer still in reset.
  always_comb begin
    ready_s        = rst & ~flush & ((state_r == IDLE) | (state_r == WRITEBACK));
    hs_s           = ib.instr_valid & ready_s;
    ib.instr_ready = ready_s;
  end

  // State, instruction register, memory-wait counter and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cls_r     <= RTYPE;
      alu_r     <= ALU_ADD;
      cnt_r     <= '0;
      illegal_r <= 1'b0;
      mem_err_r <= 1'b0;
    end else begin
      illegal_r <= 1'b0;
      mem_err_r <= 1'b0;
      if (flush) begin
        state_r <= IDLE;
      end else begin
        case (state_r)
          IDLE, WRITEBACK: begin
            if (hs_s && legal_s) begin
              state_r <= DECODE;
              cls_r   <= cls_s;
              alu_r   <= alu_s;
            end else begin
              state_r   <= IDLE;
              illegal_r <= hs_s;
            end
          end
          DECODE: state_r <= EXECUTE;
          EXECUTE: begin
            state_r <= MEMORY;
            cnt_r   <= '0;
          end
          MEMORY: begin
            // The current wait cycle counts toward the limit, so the last allowed one fires the timeout.
            if ((cls_r != LOAD && cls_r != STORE) || mem_ready) begin
              state_r <= WRITEBACK;
            end else if (cnt_r == TO_W'(MEM_TIMEOUT - 1)) begin
              state_r   <= IDLE;
              mem_err_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + TO_W'(1);
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  // Moore control-word decode from state and the latched instruction class.
  always_comb begin
    cw_s = '0;
    case (state_r)
      DECODE: begin
        cw_s[CW_EN1] = 1'b1;
        cw_s[CW_RF1] = (cls_r != NOP);
        cw_s[CW_RF2] = (cls_r == RTYPE) || (cls_r == STORE);
      end
      EXECUTE: begin
        cw_s[CW_EN2]  = 1'b1;
        cw_s[CW_S1]   = (cls_r != NOP);
        cw_s[CW_S2]   = (cls_r == ITYPE) || (cls_r == LOAD) || (cls_r == STORE);
        cw_s[CW_ALU1] = alu_r[1];
        cw_s[CW_ALU2] = alu_r[0];
      end
      MEMORY: begin
        cw_s[CW_EN3] = 1'b1;
        cw_s[CW_RM]  = (cls_r == LOAD);
        cw_s[CW_WM]  = (cls_r == STORE);
      end
      WRITEBACK: begin
        cw_s[CW_WF1] = (cls_r != STORE) && (cls_r != NOP);
        cw_s[CW_S3]  = (cls_r == LOAD);
      end
      default: cw_s = '0;
    endcase
  end

  assign cw      = cw_s;
  assign busy    = (state_r != IDLE);
  assign done    = (state_r == WRITEBACK);
  assign illegal = illegal_r;
  assign mem_err = mem_err_r;

endmodule

// File: doc/cw_seq_ctrl.md
# cw_seq_ctrl

Multi-cycle, handshaked control-word sequencer for the three-stage datapath. It is the parametrised successor of the hardwired control FSM. It accepts one instruction (opcode/func) per handshake, walks it through DECODE → EXECUTE → MEMORY → WRITEBACK, and emits the 13-bit control word for each stage. Additional behaviour: memory wait states with timeout, illegal-instruction detection, flush, and back-to-back issue from WRITEBACK.

## Interface
- OP_CODE_SIZE, 6, opcode width
- FUNC_SIZE, 11, func width
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready in MEMORY (≥1)
- TO_W, $clog2(MEM_TIMEOUT+1), timeout counter width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept
- opcode  in  OP_CODE_SIZE  sampled on handshake
- func  in  FUNC_SIZE  sampled on handshake
- mem_ready  in  1  data memory completes access this cycle
- flush  in  1  synchronous abort of in-flight instruction
- cw  out  13  control word: [12]rf1 [11]rf2 [10]en1 [9]s1 [8]s2 [7]alu1 [6]alu2 [5]en2 [4]rm [3]wm [2]en3 [1]s3 [0]wf1
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse in WRITEBACK
- illegal  out  1  one-cycle pulse, rejected encoding
- mem_err  out  1  one-cycle pulse, memory timeout

## Operation
- Supported encodings:
  - R-type (opcode 0x00): ADD func 0x020, SUB 0x022, AND 0x024, OR 0x025.
  - I-type: ADDI 0x08, SUBI 0x0A, ANDI 0x0C, ORI 0x0D, LW 0x23, SW 0x2B, NOP 0x15.
  - Anything else is illegal.
- ALU op {alu1,alu2}: 00 add, 01 sub, 10 and, 11 or. LW/SW use add.
- Handshake occurs when instr_valid & instr_ready. opcode/func are latched into an instruction register.
- instr_ready = 1 in IDLE and in WRITEBACK, and 0 while flush is asserted.
- States and transitions:
  - IDLE: accept legal → DECODE; accept illegal → stay IDLE, illegal pulse next cycle, no cw bit set.
  - DECODE: cw sets rf1, en1; rf2 set for R-type and SW. → EXECUTE.
  - EXECUTE: cw sets en2, s1, alu op; s2=1 (immediate) for I-type/LW/SW, 0 for R-type. → MEMORY.
  - MEMORY: en3=1; rm=1 for LW, wm=1 for SW.
    - Non-memory ops → WRITEBACK after 1 cycle.
    - LW/SW hold until mem_ready=1, then → WRITEBACK.
    - If mem_ready is still 0 after MEM_TIMEOUT cycles in MEMORY → IDLE with a mem_err pulse; no WRITEBACK for that instruction.
  - WRITEBACK: wf1=1 except SW and NOP; s3=1 for LW, else 0; done=1. If a new handshake occurs → DECODE, else → IDLE.
- NOP traverses all states with only en1/en2/en3 set.
- flush=1 forces IDLE on the next edge from any state and drops the instruction (no done). It overrides mem_ready, timeout, and handshake.
- The timeout counter clears on entry to MEMORY. It counts each cycle mem_ready=0. Timeout fires when the count equals MEM_TIMEOUT.

## Timing
- Reset state (async assert, sync release): state IDLE, cw=0, busy=0, done=0, illegal=0, mem_err=0, instr_ready=1 after release, counter 0, instruction register 0.
- Reset mid-operation aborts immediately; no pulse outputs.
- cw, busy, done: Moore-decoded from registered state and instruction register; no combinational path from inputs.
- mem_err, illegal: registered pulses, asserted the cycle after the causing event, with state already IDLE.
- Latency:
  - Handshake at edge k: DECODE cycle k+1, EXECUTE k+2, MEMORY k+3, WRITEBACK k+4 when there is no wait.
  - Each mem_ready=0 cycle adds one.
- Issue interval is 4 cycles back-to-back, because WRITEBACK accepts the next instruction.
- Timeout: WRITEBACK never entered; IDLE on cycle k+3+MEM_TIMEOUT.

## Structure
- Package cw_seq_pkg: state enum (IDLE, DECODE, EXECUTE, MEMORY, WRITEBACK), opcode/func localparams, cw bit-index constants, ALU op encodings, instruction-class enum (RTYPE, ITYPE, LOAD, STORE, NOP).
- Sub-module cw_decode: combinational opcode/func → {class, alu_op, legal}. The top holds the state register, instruction register, timeout counter, pulse registers and cw decode.

## Test plan
- Reset → ADD (0x00/0x020) with instr_valid held → DECODE cw=0x1C00, EXECUTE cw=0x0220, MEMORY cw=0x0004, WRITEBACK cw=0x0001 with done=1; next instruction accepted in WRITEBACK.
- LW (0x23) with mem_ready low for 3 cycles → MEMORY cw=0x0014 held 4 cycles, WRITEBACK cw=0x0003.
- SW (0x2B) with mem_ready never high, MEM_TIMEOUT=15 → mem_err one pulse at handshake+18, no done, instr_ready=1.
- Opcode 0x3F → illegal pulse next cycle, busy stays 0, cw=0.
- flush asserted in EXECUTE of ORI (0x0D), then in MEMORY wait of LW, with simultaneous mem_ready=1 → IDLE next cycle, no done, no wf1.
- rst driven low mid-MEMORY → all outputs 0 immediately; after release, SUBI (0x0A) completes normally with ALU op 01.
